// File: rtl/matrix_result_streamer.sv
// Purpose: captures a 4x4 complex result matrix, rounds/saturates it, streams it row-major.
// Latency: element [0][0] is valid the cycle after capture; at least 16 cycles per matrix.
// Backpressure: out_ready=0 holds the current element; in_ready only while idle or on the final accepted beat.
module matrix_result_streamer #(
  parameter int w     = 16,
  parameter int SHIFT = 0,
  parameter int OW    = 2*w+3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [2*w+2:0]  C_real [0:3][0:3],
  input  logic signed [2*w+2:0]  C_imag [0:3][0:3],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OW-1:0]   out_real,
  output logic signed [OW-1:0]   out_imag,
  output logic [1:0]             out_row,
  output logic [1:0]             out_col,
  output logic                   out_last,
  output logic                   out_sat,
  output logic                   busy
);

  // Input element width and the one-bit-wider working width for the rounding add.
  localparam int XW = 2*w+3;
  localparam int TW = 2*w+4;

  // Rounding constant is half an LSB of the shifted result; zero when no shift.
  localparam logic signed [TW-1:0] ONE  = TW'(1);
  localparam int                   RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [TW-1:0] RND  = (SHIFT > 0) ? (ONE <<< RSH) : '0;

  // Saturation limits; an output at least as wide as the working width never clips.
  localparam int                   OWL  = (OW < TW) ? OW : TW;
  localparam logic signed [TW-1:0] MAXV = (ONE <<< (OWL-1)) - ONE;
  localparam logic signed [TW-1:0] MINV = -(ONE <<< (OWL-1));

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_idx;
  logic [3:0]            w_idx_nxt;
  logic                  w_capture;

  logic signed [OW-1:0]  r_buf_real [16];
  logic signed [OW-1:0]  r_buf_imag [16];
  logic                  r_buf_sat  [16];

  logic [OW:0]           w_conv_real [16];
  logic [OW:0]           w_conv_imag [16];

  // Round-half-up right shift followed by clamp; returns {sat, value}.
  function automatic logic [OW:0] conv(input logic signed [XW-1:0] x);
    logic signed [TW-1:0] t;
    logic signed [OW-1:0] v;
    logic                 sat;
    t   = (TW'(x) + RND) >>> SHIFT;
    sat = 1'b0;
    if (t > MAXV) begin
      v   = OW'(MAXV);
      sat = 1'b1;
    end else if (t < MINV) begin
      v   = OW'(MINV);
      sat = 1'b1;
    end else begin
      v   = OW'(t);
    end
    return {sat, v};
  endfunction

  // Convert every element of the incoming matrix so the buffer holds final values.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_conv_real[k] = '0;
      w_conv_imag[k] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_conv_real[4*i+j] = conv(C_real[i][j]);
        w_conv_imag[4*i+j] = conv(C_imag[i][j]);
      end
    end
  end

  // Next-state, next-index and the combinational in_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = ST_STREAM;
          w_idx_nxt   = 4'd0;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (r_idx == 4'd15) begin
            // Final beat leaves: a waiting matrix can slide in with no bubble.
            in_ready  = 1'b1;
            w_idx_nxt = 4'd0;
            if (!in_valid) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  assign w_capture = in_valid & in_ready;

  // State and element index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Matrix buffer: loaded with converted values on capture, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        r_buf_real[k] <= '0;
        r_buf_imag[k] <= '0;
        r_buf_sat[k]  <= 1'b0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < 16; k++) begin
        r_buf_real[k] <= w_conv_real[k][OW-1:0];
        r_buf_imag[k] <= w_conv_imag[k][OW-1:0];
        r_buf_sat[k]  <= w_conv_real[k][OW] | w_conv_imag[k][OW];
      end
    end
  end

  // Outputs are straight reads of registered state.
  assign out_valid = (r_state == ST_STREAM);
  assign busy      = (r_state == ST_STREAM);
  assign out_real  = r_buf_real[r_idx];
  assign out_imag  = r_buf_imag[r_idx];
  assign out_sat   = r_buf_sat[r_idx];
  assign out_row   = r_idx[3:2];
  assign out_col   = r_idx[1:0];
  assign out_last  = out_valid & (r_idx == 4'd15);

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: two instances (full width, and SHIFT=3/OW=16) share stimulus.
// A queue-based model predicts every beat and in_ready; tables cover the rounding/saturation edges.
module tb_matrix_result_streamer;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                out_ready;
  logic signed [34:0]  C_real [0:3][0:3];
  logic signed [34:0]  C_imag [0:3][0:3];

  logic                in_ready0, out_valid0, out_last0, out_sat0, busy0;
  logic signed [34:0]  out_real0, out_imag0;
  logic [1:0]          out_row0, out_col0;
  logic                in_ready1, out_valid1, out_last1, out_sat1, busy1;
  logic signed [15:0]  out_real1, out_imag1;
  logic [1:0]          out_row1, out_col1;

  always #5 clk = ~clk;

  matrix_result_streamer #(.w(16), .SHIFT(0), .OW(35)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .C_real(C_real), .C_imag(C_imag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_real(out_real0), .out_imag(out_imag0), .out_row(out_row0), .out_col(out_col0),
    .out_last(out_last0), .out_sat(out_sat0), .busy(busy0)
  );

  matrix_result_streamer #(.w(16), .SHIFT(3), .OW(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .C_real(C_real), .C_imag(C_imag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_real(out_real1), .out_imag(out_imag1), .out_row(out_row1), .out_col(out_col1),
    .out_last(out_last1), .out_sat(out_sat1), .busy(busy1)
  );

  typedef struct {
    longint r0, i0, r1, i1;
    bit     s0, s1;
    int     row, col;
  } beat_t;

  typedef struct {
    longint x;
    longint exp16;
    bit     sat16;
  } vec_t;

  beat_t  pend[$];
  longint cr[16];
  longint ci[16];
  int     checks   = 0;
  int     failures = 0;
  int     dut_acc  = 0;
  bit     last_cap = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rounding shift and clamp expressed with plain integer arithmetic.
  function automatic longint conv(input longint x, input int sh, input int ow, output bit sat);
    longint one, t, mx, mn;
    one = 1;
    if (sh == 0) t = x;
    else         t = (x + (one << (sh-1))) >>> sh;
    mx  = (one << (ow-1)) - 1;
    mn  = -(one << (ow-1));
    sat = 0;
    if (t > mx) begin t = mx; sat = 1; end
    else if (t < mn) begin t = mn; sat = 1; end
    return t;
  endfunction

  function automatic longint rand35();
    longint v;
    if ($urandom_range(0, 1) == 0) begin
      v = longint'($urandom_range(0, 600000)) - 300000;
    end else begin
      v = {$urandom, $urandom};
      v = (v <<< 29) >>> 29;
    end
    return v;
  endfunction

  task automatic rand_matrix();
    for (int k = 0; k < 16; k++) begin
      cr[k] = rand35();
      ci[k] = rand35();
    end
  endtask

  task automatic zero_matrix();
    for (int k = 0; k < 16; k++) begin
      cr[k] = 0;
      ci[k] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        C_real[i][j] = 35'(cr[4*i+j]);
        C_imag[i][j] = 35'(ci[4*i+j]);
      end
  endtask

  task automatic push_matrix();
    beat_t b;
    bit sa, sb;
    for (int k = 0; k < 16; k++) begin
      b.r0 = conv(cr[k], 0, 35, sa);
      b.i0 = conv(ci[k], 0, 35, sb);
      b.s0 = sa | sb;
      b.r1 = conv(cr[k], 3, 16, sa);
      b.i1 = conv(ci[k], 3, 16, sb);
      b.s1 = sa | sb;
      b.row = k / 4;
      b.col = k % 4;
      pend.push_back(b);
    end
  endtask

  // One clock: compare everything against the model, advance the model, move to next negedge.
  task automatic step();
    bit    exp_rdy, acc, cap, vld;
    beat_t b;
    drive();
    #1;
    vld     = (pend.size() > 0);
    exp_rdy = !rst && (pend.size() == 0 || (pend.size() == 1 && out_ready));
    chk("in_ready0", in_ready0, exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    chk("out_valid0", out_valid0, vld);
    chk("out_valid1", out_valid1, vld);
    chk("busy0", busy0, vld);
    chk("busy1", busy1, vld);
    if (vld) begin
      b = pend[0];
      chk("real0", out_real0, b.r0);
      chk("imag0", out_imag0, b.i0);
      chk("sat0",  out_sat0,  b.s0);
      chk("row0",  out_row0,  b.row);
      chk("col0",  out_col0,  b.col);
      chk("last0", out_last0, (b.row == 3 && b.col == 3));
      chk("real1", out_real1, b.r1);
      chk("imag1", out_imag1, b.i1);
      chk("sat1",  out_sat1,  b.s1);
      chk("row1",  out_row1,  b.row);
      chk("col1",  out_col1,  b.col);
      chk("last1", out_last1, (b.row == 3 && b.col == 3));
    end else begin
      chk("last0_idle", out_last0, 0);
      chk("last1_idle", out_last1, 0);
    end
    if (out_valid0 && out_ready && !rst) dut_acc++;
    acc = !rst && vld && out_ready;
    cap = in_valid && exp_rdy;
    if (acc) b = pend.pop_front();
    if (rst) pend.delete();
    if (cap) push_matrix();
    last_cap = cap;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready0"}, in_ready0, 0);
    chk({tag, "_out_valid0"}, out_valid0, 0);
    chk({tag, "_real0"}, out_real0, 0);
    chk({tag, "_imag0"}, out_imag0, 0);
    chk({tag, "_rowcol0"}, {out_row0, out_col0}, 0);
    chk({tag, "_lastsat0"}, {out_last0, out_sat0, busy0}, 0);
    chk({tag, "_in_ready1"}, in_ready1, 0);
    chk({tag, "_out_valid1"}, out_valid1, 0);
    chk({tag, "_real1"}, out_real1, 0);
    chk({tag, "_imag1"}, out_imag1, 0);
    chk({tag, "_rowcol1"}, {out_row1, out_col1}, 0);
    chk({tag, "_lastsat1"}, {out_last1, out_sat1, busy1}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    longint v;
    tbl = '{
      '{13, 2, 0}, '{-13, -2, 0}, '{-12, -1, 0}, '{1000000, 32767, 1},
      '{-1000000, -32768, 1}, '{4, 1, 0}, '{262139, 32767, 0}, '{262140, 32767, 1},
      '{-262148, -32768, 0}, '{-262149, -32768, 1}
    };

    // Reset: two cycles with rst high, everything reads zero.
    rst = 1; in_valid = 0; out_ready = 0;
    zero_matrix();
    drive();
    @(negedge clk);
    check_zero("rst_a");
    @(negedge clk);
    check_zero("rst_b");
    rst = 0;
    #1;
    chk("rel_in_ready0", in_ready0, 1);
    chk("rel_in_ready1", in_ready1, 1);
    chk("rel_out_valid0", out_valid0, 0);
    chk("rel_out_valid1", out_valid1, 0);

    // Ramp matrix at full width: row-major values, out_last on the 16th beat only.
    for (int k = 0; k < 16; k++) begin
      cr[k] = 16*(k/4) + (k%4);
      ci[k] = -cr[k];
    end
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      v = 16*(k/4) + (k%4);
      chk("ramp_valid", out_valid0, 1);
      chk("ramp_real", out_real0, v);
      chk("ramp_imag", out_imag0, -v);
      chk("ramp_last", out_last0, (k == 15));
      step();
    end
    step();

    // Rounding and saturation table on element [0][0].
    foreach (tbl[n]) begin
      zero_matrix();
      cr[0] = tbl[n].x;
      in_valid = 1; out_ready = 1;
      step();
      in_valid = 0;
      #1;
      chk("tbl_real16", out_real1, tbl[n].exp16);
      chk("tbl_sat16", out_sat1, tbl[n].sat16);
      chk("tbl_real35", out_real0, tbl[n].x);
      chk("tbl_sat35", out_sat0, 0);
      repeat (16) step();
    end

    // Stalls: out_ready 1,0,0 repeating; exactly 16 accepts.
    rand_matrix();
    in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    dut_acc = 0;
    for (int c = 0; c < 80 && pend.size() > 0; c++) begin
      out_ready = (c % 3 == 0);
      step();
    end
    chk("stall_drain", pend.size(), 0);
    chk("stall_accepts", dut_acc, 16);

    // Back-to-back: a new matrix waits on in_valid and slides in on element 15.
    rand_matrix();
    in_valid = 1; out_ready = 1;
    step();
    for (int c = 0; c < 40; c++) begin
      if (last_cap) rand_matrix();
      step();
      chk("b2b_busy", busy0, 1);
    end
    in_valid = 0;
    for (int c = 0; c < 20 && pend.size() > 0; c++) step();

    // Reset during element 7 aborts the matrix; a fresh one starts at [0][0].
    rand_matrix();
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    for (int c = 0; c < 20 && pend.size() > 9; c++) step();
    chk("mid_row", out_row0, 1);
    chk("mid_col", out_col0, 3);
    rst = 1;
    step();
    check_zero("mid_rst");
    rst = 0;
    rand_matrix();
    in_valid = 1;
    step();
    in_valid = 0;
    #1;
    chk("fresh_rowcol", {out_row0, out_col0}, 0);
    chk("fresh_real", out_real0, cr[0]);
    for (int c = 0; c < 20 && pend.size() > 0; c++) step();

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 1500; c++) begin
      rand_matrix();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; in_valid = 0; out_ready = 1;
    for (int c = 0; c < 40 && pend.size() > 0; c++) step();
    chk("final_drain", pend.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
